// File: rtl/cluster_vector_loader.sv
// cluster_vector_loader
//   Upstream feed stage for the cluster_1 output-bit circuits. Collects the
//   cluster input vector as a stream of WORD_W-bit words, holds it stable on
//   vec_o while the cluster settles, then samples the cluster result bits and
//   offers them downstream.
//
// Parameters
//   VEC_W   assembled vector width
//   WORD_W  load word width
//   OUT_W   result width
//   SETTLE  cycles from vec_valid rising to result sampling (1..15)
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   load word handshake, in_data word k -> vec_o[k*WORD_W +: WORD_W]
//   flush               synchronous abort to IDLE (vec_o contents kept)
//   vec_o, vec_valid    assembled vector and its "complete and stable" flag
//   res_i               combinational result bits from the cluster
//   res_o, res_valid,
//   res_ready           registered result and its downstream handshake
//   word_cnt            index of next expected word
//
// Optional build macro WORD_PARITY_EN adds:
//   in_par   even parity bit over in_data
//   par_err  sticky parity error, cleared by rst or flush
module cluster_vector_loader #(
    parameter int unsigned VEC_W  = 1894,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              flush,
    output logic [VEC_W-1:0]  vec_o,
    output logic              vec_valid,
    input  logic [OUT_W-1:0]  res_i,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OUT_W-1:0]  res_o,
    output logic [5:0]        word_cnt
`ifdef WORD_PARITY_EN
    ,
    input  logic              in_par,
    output logic              par_err
`endif
);

    localparam int unsigned NWORDS = (VEC_W + WORD_W - 1) / WORD_W;
    localparam int unsigned SH_W   = $clog2(NWORDS * WORD_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RESULT
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_settle;
    logic              w_accept;
    logic              w_last;
    logic [SH_W-1:0]   w_shamt;
    logic [VEC_W-1:0]  w_word_data;
    logic [VEC_W-1:0]  w_word_mask;

    assign w_last = (word_cnt == 6'(NWORDS - 1));

    // Word placement by shifting into a VEC_W-wide lane: bits of the final
    // word beyond VEC_W fall off the top, so only its low bits are stored.
    assign w_shamt     = SH_W'(word_cnt) * SH_W'(WORD_W);
    assign w_word_data = VEC_W'(in_data) << w_shamt;
    assign w_word_mask = VEC_W'({WORD_W{1'b1}}) << w_shamt;

    assign w_accept = in_valid & in_ready & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        vec_valid    = 1'b0;
        res_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = ~rst;
                if (in_valid) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = ~rst;
                if (in_valid && w_last) begin
                    w_state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                vec_valid = 1'b1;
                if (r_settle == 4'd0) begin
                    w_state_next = S_RESULT;
                end
            end
            S_RESULT: begin
                vec_valid = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        // flush overrides any accept or handshake in the same cycle
        if (flush) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_o    <= '0;
            word_cnt <= '0;
            r_settle <= '0;
            res_o    <= '0;
        end else begin
            if (flush) begin
                word_cnt <= '0;
            end else if (w_accept) begin
                vec_o    <= (vec_o & ~w_word_mask) | (w_word_data & w_word_mask);
                word_cnt <= w_last ? 6'd0 : word_cnt + 6'd1;
            end

            if (w_accept && w_last) begin
                r_settle <= 4'(SETTLE - 1);
            end else if (r_state == S_SETTLE && r_settle != 4'd0) begin
                r_settle <= r_settle - 4'd1;
            end

            if (r_state == S_SETTLE && r_settle == 4'd0 && !flush) begin
                res_o <= res_i;
            end
        end
    end

`ifdef WORD_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err <= 1'b0;
        end else if (flush) begin
            par_err <= 1'b0;
        end else if (w_accept && ((^in_data) != in_par)) begin
            par_err <= 1'b1;
        end
    end
`endif

endmodule
